// File: rtl/tow_pkg.sv
// Shared types and constants for the Tug-of-War round referee.
package tow_pkg;

   typedef enum logic [2:0] {
      ARM,
      PLAY,
      REPORT,
      GAP,
      DONE
   } state_e;

   localparam int          ROPE_W         = 7;
   localparam logic [2:0]  ROPE_CENTRE    = 3'd3;
   localparam logic [2:0]  ROPE_LEFT_END  = 3'd6;
   localparam logic [2:0]  ROPE_RIGHT_END = 3'd0;

   // Downstream 2-flop synchronizer plus one-pulse stage needs the level this long.
   localparam int          MIN_HOLD       = 3;

   function automatic logic [ROPE_W-1:0] pos_to_led(input logic [2:0] pos);
      return ROPE_W'(1) << pos;
   endfunction

endpackage

// File: rtl/round_referee_if.sv
// Button/tally-side signal bundle of the round referee.
interface round_referee_if;
   import tow_pkg::*;

   logic              pbl;
   logic              pbr;
   logic              over;
   logic              rw;
   logic              wingame;
   logic [ROPE_W-1:0] rope_LED;

   modport master (
      output pbl, pbr, over,
      input  rw, wingame, rope_LED
   );

   modport slave (
      input  pbl, pbr, over,
      output rw, wingame, rope_LED
   );

endinterface

// File: rtl/press_edge.sv
// Registers one debounced button and emits a one-cycle pulse on its rising edge.
module press_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   logic btn_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q <= 1'b0;
      end else begin
         btn_q <= btn_i;
      end
   end

   assign press_o = btn_i & ~btn_q;

endmodule

// File: rtl/round_referee.sv
// Tug-of-War round referee: moves the rope marker on button presses and
// reports each round's winner to the tally block as an rw/wingame level.
module round_referee
   import tow_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 16
) (
   input  logic            clk,
   input  logic            rst,
   round_referee_if.slave  bus
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   if (HOLD_CYCLES < MIN_HOLD) begin : g_bad_hold
      $error("round_referee: HOLD_CYCLES too short for the tally synchronizer");
   end

   state_e            state_q;
   logic [2:0]        pos_q;
   logic [ROPE_W-1:0] rope_q;
   logic              rw_q;
   logic              wingame_q;
   logic [HOLD_W-1:0] hold_q;
   logic [GAP_W-1:0]  gap_q;
   logic              over_seen_q;

   logic              press_l;
   logic              press_r;
   logic [2:0]        pos_d;
   logic              at_end;

   press_edge u_edge_l (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus.pbl),
      .press_o (press_l)
   );

   press_edge u_edge_r (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus.pbr),
      .press_o (press_r)
   );

   // A tie cancels out; in PLAY pos is always 1..5, so a single step cannot wrap.
   always_comb begin
      pos_d = pos_q;
      if (press_l && !press_r) begin
         pos_d = pos_q + 3'd1;
      end else if (press_r && !press_l) begin
         pos_d = pos_q - 3'd1;
      end
   end

   assign at_end = (pos_d == ROPE_LEFT_END) || (pos_d == ROPE_RIGHT_END);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARM;
         pos_q       <= ROPE_CENTRE;
         rope_q      <= pos_to_led(ROPE_CENTRE);
         rw_q        <= 1'b0;
         wingame_q   <= 1'b0;
         hold_q      <= '0;
         gap_q       <= '0;
         over_seen_q <= 1'b0;
      end else begin
         case (state_q)
            ARM: begin
               if (bus.over) begin
                  state_q <= DONE;
               end else if (!bus.pbl && !bus.pbr) begin
                  state_q <= PLAY;
               end
            end

            PLAY: begin
               if (bus.over) begin
                  state_q <= DONE;
               end else begin
                  pos_q  <= pos_d;
                  rope_q <= pos_to_led(pos_d);
                  if (at_end) begin
                     state_q     <= REPORT;
                     hold_q      <= '0;
                     over_seen_q <= 1'b0;
                  end
               end
            end

            // hold_q==0 marks the first REPORT cycle; the result rises one clock after the marker lands.
            REPORT: begin
               if (bus.over) begin
                  over_seen_q <= 1'b1;
               end
               if (hold_q == '0) begin
                  wingame_q <= 1'b1;
                  rw_q      <= (pos_q == ROPE_RIGHT_END);
                  hold_q    <= HOLD_W'(1);
               end else if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
                  wingame_q <= 1'b0;
                  rw_q      <= 1'b0;
                  hold_q    <= '0;
                  gap_q     <= '0;
                  state_q   <= (over_seen_q || bus.over) ? DONE : GAP;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end

            GAP: begin
               if (bus.over) begin
                  state_q <= DONE;
               end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                  gap_q   <= '0;
                  pos_q   <= ROPE_CENTRE;
                  rope_q  <= pos_to_led(ROPE_CENTRE);
                  state_q <= ARM;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end

            DONE: begin
            end

            default: begin
               state_q <= ARM;
            end
         endcase
      end
   end

   assign bus.rw       = rw_q;
   assign bus.wingame  = wingame_q;
   assign bus.rope_LED = rope_q;

endmodule

// File: doc/round_referee.md
Name: round_referee

Overview:
- Produces round results for one Tug-of-War game and drives the game tally block, which counts wins and asserts over.
- Takes debounced left and right push-buttons and moves a 7-position rope marker one step per press.
- When the marker reaches an end, reports the round winner on the rw/wingame interface, then re-centres for the next round.
- Freezes when the tally block asserts over.

Parameters:
- HOLD_CYCLES, 4: cycles rw/wingame are held asserted per report; must be >= 3 so the downstream 2-flop synchronizer plus one-pulse stage catches the level.
- GAP_CYCLES, 16: minimum dead time after a report before play resumes; all outputs are quiet during the gap.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- pbl  input  1  left player button, debounced, level, synchronous to clk
- pbr  input  1  right player button, debounced, level, synchronous to clk
- over  input  1  game-over from the tally block; level
- rw  output  1  right-won qualifier; high with wingame for a right win
- wingame  output  1  round-result strobe (level, HOLD_CYCLES long)
- rope_LED  output  7  one-hot rope marker; bit 3 is centre, bit 0 is the right end, bit 6 is the left end

Behaviour:
- Reset values:
  - rw=0, wingame=0, rope_LED=7'b0001000 (pos=3).
  - State ARM; edge registers and hold/gap counters cleared.
- Edge detect:
  - pbl_q and pbr_q are registered copies of the buttons.
  - pressL = pbl & ~pbl_q; pressR = pbr & ~pbr_q.
  - Presses are acted on only in PLAY.
- Position:
  - 3-bit pos, range 0..6; rope_LED = 1 << pos, registered.
  - In PLAY, pressL alone: pos+1 (toward the left end). pressR alone: pos-1.
  - Both pressL and pressR in the same cycle: no move (tie).
  - pos never wraps: a move that lands on 6 or 0 ends the round in that same update.
- FSM states ARM, PLAY, REPORT, GAP, DONE:
  - ARM: wait until pbl=0 and pbr=0 (no held button carries into a round) -> PLAY. If over=1 -> DONE.
  - PLAY: pos becomes 6 -> REPORT, with rw=0 and wingame=1 asserted from the next clock. pos becomes 0 -> REPORT, with rw=1 and wingame=1. If over=1 -> DONE.
  - REPORT: hold rw/wingame unchanged for exactly HOLD_CYCLES cycles. Then clear both in the same cycle and go to GAP. pos remains at the end position during REPORT.
  - GAP: count GAP_CYCLES cycles, then set pos=3 and go to ARM. If over=1 at any point -> DONE, leaving pos at its end value.
  - DONE: absorbing until rst. rw=0, wingame=0, rope_LED frozen.
- Interface rules for the tally block:
  - rw is never high without wingame.
  - rw and wingame rise in the same cycle and fall in the same cycle. The downstream rule lw = ~rw & wingame then produces no spurious left win.
  - Minimum low time between reports is GAP_CYCLES plus the ARM time, which is >= 3 cycles.
- Simultaneous events:
  - over rising while in REPORT: finish the hold first (the report completes), then go to DONE instead of GAP.
  - Button activity in REPORT, GAP or DONE is ignored and does not move pos.
- rst mid-operation:
  - Immediately forces the reset values, including dropping an in-progress wingame.
  - The tally block is reset by the same rst.
- Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(GAP_CYCLES+1); saturate, never wrap.

Decomposition:
- Shared package (tow_pkg):
  - State enum.
  - ROPE_CENTRE=3, ROPE_LEFT_END=6, ROPE_RIGHT_END=0.
  - MIN_HOLD=3.
- One natural sub-module, press_edge: registers a button and emits its rising-edge pulse. Instantiated twice.
- FSM, position and counters live in round_referee.

Test Plan:
- Reset, then 3 isolated pbl presses (1 cycle high, 3 low each):
  - rope_LED steps 0x08 -> 0x10 -> 0x20 -> 0x40.
  - Next cycle wingame=1, rw=0 for exactly 4 cycles.
  - After GAP_CYCLES, rope_LED=0x08.
- Reset, then 3 pbr presses:
  - rope_LED goes 0x08 -> 0x04 -> 0x02 -> 0x01.
  - wingame=1 and rw=1 rise together, fall together after 4 cycles.
  - rw is never seen high alone.
- pbl and pbr rising in the same cycle, repeated 5 times: rope_LED stays 0x08 and wingame stays 0.
- pbl held high across end of GAP:
  - Remains in ARM with no move.
  - Release, then press once: rope_LED=0x10.
- over asserted during REPORT:
  - wingame still completes 4 cycles, then state DONE.
  - Further presses leave rope_LED at 0x40 and outputs at 0 until rst.
- rst pulsed in the 2nd cycle of REPORT: wingame=0, rw=0 and rope_LED=0x08 asynchronously, and the FSM is in ARM.
